// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, control-bundle field map and the ID/EX payload struct
package pipeline_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int CTRL_W = 16;
  localparam int CTRL_LOAD_BIT = 8;
  localparam int CTRL_WRE_BIT = 7;
  localparam int CTRL_WME_BIT = 6;
  localparam int CTRL_WB_LSB = 4;
  localparam int CTRL_ALU_LSB = 0;
  localparam logic [CTRL_W-1:0] CTRL_NOP = 16'h0000;
  localparam logic [CTRL_W-1:0] CTRL_MASK = 16'h01FF;
  typedef struct packed {
    logic valid;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm;
  } id_ex_t;
endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: combinational load-use hazard compare between EX and decode
import pipeline_pkg::*;
module load_use_detector (
  input  logic              ex_valid_i,
  input  logic              ex_load_i,
  input  logic              ex_wre_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic              id_rs1_used_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs2_used_i,
  output logic              hazard_o
);
  assign hazard_o = ex_valid_i & ex_load_i & ex_wre_i & id_valid_i &
                    ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                     (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
endmodule

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with load-use bubble, flush and hold; ID_EX_PERF_CNT_EN adds a bubble counter
import pipeline_pkg::*;
module id_ex_register (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [DATA_W-1:0] id_op_a_i,
  input  logic [DATA_W-1:0] id_op_b_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic              ex_hold_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [DATA_W-1:0] ex_op_a_o,
  output logic [DATA_W-1:0] ex_op_b_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic              stall_upstream_o,
  output logic [31:0]       bubble_count_o
);
  id_ex_t stage_q, stage_d, in_s;
  logic hazard;

  load_use_detector u_lud (
    .ex_valid_i   (stage_q.valid),
    .ex_load_i    (stage_q.ctrl[CTRL_LOAD_BIT]),
    .ex_wre_i     (stage_q.ctrl[CTRL_WRE_BIT]),
    .ex_rd_i      (stage_q.rd),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs2_used_i(id_rs2_used_i),
    .hazard_o     (hazard)
  );

  assign stall_upstream_o = hazard | ex_hold_i;

  // Next payload: flush beats hold beats hazard; invalid slots carry a NOP control word
  always_comb begin
    in_s = '{valid: id_valid_i,
             ctrl:  id_valid_i ? (id_ctrl_i & CTRL_MASK) : CTRL_NOP,
             rs1:   id_rs1_i,
             rs2:   id_rs2_i,
             rd:    id_rd_i,
             op_a:  id_op_a_i,
             op_b:  id_op_b_i,
             imm:   id_imm_i};
    stage_d = flush_i ? '0 : ex_hold_i ? stage_q : hazard ? '0 : in_s;
  end

  // Stage register, cleared to a bubble by async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign ex_valid_o = stage_q.valid;
  assign ex_ctrl_o  = stage_q.ctrl;
  assign ex_rs1_o   = stage_q.rs1;
  assign ex_rs2_o   = stage_q.rs2;
  assign ex_rd_o    = stage_q.rd;
  assign ex_op_a_o  = stage_q.op_a;
  assign ex_op_b_o  = stage_q.op_b;
  assign ex_imm_o   = stage_q.imm;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic bubble;

  // Saturating count of edges that load a bubble via flush or hazard
  always_comb begin
    bubble = flush_i | (~ex_hold_i & hazard);
    cnt_d  = (bubble && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
  end

  // Counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bubble_count_o = cnt_q;
`else
  assign bubble_count_o = 32'd0;
`endif
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: directed self-checking bench for id_ex_register
module tb_id_ex_register;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        id_valid_i = 0;
  logic [15:0] id_ctrl_i = 0;
  logic [3:0]  id_rs1_i = 0, id_rs2_i = 0, id_rd_i = 0;
  logic        id_rs1_used_i = 0, id_rs2_used_i = 0;
  logic [31:0] id_op_a_i = 0, id_op_b_i = 0, id_imm_i = 0;
  logic        ex_hold_i = 0, flush_i = 0;
  logic        ex_valid_o;
  logic [15:0] ex_ctrl_o;
  logic [3:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [31:0] ex_op_a_o, ex_op_b_o, ex_imm_o;
  logic        stall_upstream_o;
  logic [31:0] bubble_count_o;
  int checks = 0;
  int errors = 0;
  int exp_bubbles = 0;

  id_ex_register dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_op_a_i(id_op_a_i), .id_op_b_i(id_op_b_i), .id_imm_i(id_imm_i),
    .ex_hold_i(ex_hold_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o),
    .ex_ctrl_o(ex_ctrl_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_op_a_o(ex_op_a_o), .ex_op_b_o(ex_op_b_o), .ex_imm_o(ex_imm_o),
    .stall_upstream_o(stall_upstream_o), .bubble_count_o(bubble_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_count();
`ifdef ID_EX_PERF_CNT_EN
    return 32'(exp_bubbles);
`else
    return 32'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [3:0] r1, input logic u1,
                       input logic [3:0] r2, input logic u2, input logic [3:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    id_valid_i = v; id_ctrl_i = c; id_rs1_i = r1; id_rs1_used_i = u1;
    id_rs2_i = r2; id_rs2_used_i = u2; id_rd_i = rd;
    id_op_a_i = a; id_op_b_i = b; id_imm_i = im;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(1'b1, 16'h0181, 4'($urandom), 1'b1, 4'($urandom), 1'b1, 4'($urandom),
          $urandom, $urandom, $urandom);
    step(); step();
    checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %h expected 0", ex_valid_o); end
    checks++; if (ex_ctrl_o !== 16'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", ex_ctrl_o); end
    checks++; if ({ex_rs1_o, ex_rs2_o, ex_rd_o} !== 12'h0) begin errors++; $display("FAIL reset_idx: got %h expected 0", {ex_rs1_o, ex_rs2_o, ex_rd_o}); end
    checks++; if ({ex_op_a_o, ex_op_b_o, ex_imm_o} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {ex_op_a_o, ex_op_b_o, ex_imm_o}); end
    checks++; if (bubble_count_o !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected 0", bubble_count_o); end
    checks++; if (stall_upstream_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %h expected 0", stall_upstream_o); end
    @(negedge clk);
    rst_n = 1;
    exp_bubbles = 0;
    step();
  endtask

  task automatic test_add();
    drive(1'b1, 16'h00B1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 32'd5, 32'd7, 32'd9);
    step();
    checks++; if (ex_ctrl_o !== 16'h00B1) begin errors++; $display("FAIL add_ctrl: got %h expected 00b1", ex_ctrl_o); end
    checks++; if (ex_rd_o !== 4'd3) begin errors++; $display("FAIL add_rd: got %h expected 3", ex_rd_o); end
    checks++; if (ex_op_a_o !== 32'd5 || ex_op_b_o !== 32'd7 || ex_imm_o !== 32'd9) begin errors++; $display("FAIL add_data: got %h %h %h expected 5 7 9", ex_op_a_o, ex_op_b_o, ex_imm_o); end
    checks++; if (ex_valid_o !== 1'b1 || ex_rs1_o !== 4'd1 || ex_rs2_o !== 4'd2) begin errors++; $display("FAIL add_idx: got v%h rs1 %h rs2 %h expected v1 1 2", ex_valid_o, ex_rs1_o, ex_rs2_o); end
  endtask

  task automatic test_ctrl_masking();
    drive(1'b0, 16'h00B1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd6, 32'd11, 32'd12, 32'd13);
    step();
    checks++; if (ex_valid_o !== 1'b0 || ex_ctrl_o !== 16'h0) begin errors++; $display("FAIL invalid_ctrl: got v%h ctrl %h expected v0 0000", ex_valid_o, ex_ctrl_o); end
    checks++; if (ex_rd_o !== 4'd6 || ex_op_a_o !== 32'd11) begin errors++; $display("FAIL invalid_data: got rd %h a %h expected 6 b", ex_rd_o, ex_op_a_o); end
    drive(1'b1, 16'hFEB1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd6, 32'd1, 32'd2, 32'd3);
    step();
    checks++; if (ex_ctrl_o !== 16'h00B1) begin errors++; $display("FAIL upper_ctrl_bits: got %h expected 00b1", ex_ctrl_o); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 16'h0181, 4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 32'd100, 32'd0, 32'd4);
    step();
    drive(1'b1, 16'h00B1, 4'd2, 1'b1, 4'd7, 1'b1, 4'd5, 32'd20, 32'd30, 32'd0);
    checks++; if (stall_upstream_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %h expected 1", stall_upstream_o); end
    step();
    exp_bubbles++;
    checks++; if (ex_valid_o !== 1'b0 || ex_ctrl_o !== 16'h0 || ex_rd_o !== 4'd0 || ex_op_a_o !== 32'd0) begin errors++; $display("FAIL lu_bubble: got v%h ctrl %h rd %h a %h expected all 0", ex_valid_o, ex_ctrl_o, ex_rd_o, ex_op_a_o); end
    checks++; if (stall_upstream_o !== 1'b0) begin errors++; $display("FAIL lu_stall_clear: got %h expected 0", stall_upstream_o); end
    step();
    checks++; if (ex_ctrl_o !== 16'h00B1 || ex_rd_o !== 4'd5 || ex_op_a_o !== 32'd20) begin errors++; $display("FAIL lu_add_enters: got ctrl %h rd %h a %h expected 00b1 5 14", ex_ctrl_o, ex_rd_o, ex_op_a_o); end
    checks++; if (bubble_count_o !== exp_count()) begin errors++; $display("FAIL lu_count: got %0d expected %0d", bubble_count_o, exp_count()); end
  endtask

  task automatic test_no_false_hazard();
    drive(1'b1, 16'h0181, 4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 32'd100, 32'd0, 32'd4);
    step();
    drive(1'b1, 16'h00B1, 4'd2, 1'b0, 4'd4, 1'b1, 4'd8, 32'd40, 32'd50, 32'd0);
    checks++; if (stall_upstream_o !== 1'b0) begin errors++; $display("FAIL nfh_stall: got %h expected 0", stall_upstream_o); end
    step();
    checks++; if (ex_valid_o !== 1'b1 || ex_ctrl_o !== 16'h00B1 || ex_rd_o !== 4'd8) begin errors++; $display("FAIL nfh_add: got v%h ctrl %h rd %h expected v1 00b1 8", ex_valid_o, ex_ctrl_o, ex_rd_o); end
  endtask

  task automatic test_flush();
    drive(1'b1, 16'h0040, 4'd3, 1'b1, 4'd4, 1'b1, 4'd0, 32'd77, 32'd88, 32'd12);
    flush_i = 1;
    step();
    flush_i = 0;
    exp_bubbles++;
    checks++; if (ex_valid_o !== 1'b0 || ex_ctrl_o !== 16'h0 || ex_op_a_o !== 32'd0) begin errors++; $display("FAIL flush_bubble: got v%h ctrl %h a %h expected 0 0 0", ex_valid_o, ex_ctrl_o, ex_op_a_o); end
    checks++; if (bubble_count_o !== exp_count()) begin errors++; $display("FAIL flush_count: got %0d expected %0d", bubble_count_o, exp_count()); end
  endtask

  task automatic test_hold();
    drive(1'b1, 16'h00B1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 32'd5, 32'd7, 32'd0);
    step();
    ex_hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0181, 4'(i + 9), 1'b1, 4'd0, 1'b0, 4'(i + 10), 32'(i + 60), 32'd1, 32'd2);
      checks++; if (stall_upstream_o !== 1'b1) begin errors++; $display("FAIL hold_stall_%0d: got %h expected 1", i, stall_upstream_o); end
      step();
      checks++; if (ex_ctrl_o !== 16'h00B1 || ex_rd_o !== 4'd3 || ex_op_a_o !== 32'd5 || ex_valid_o !== 1'b1) begin errors++; $display("FAIL hold_keep_%0d: got ctrl %h rd %h a %h v%h expected 00b1 3 5 v1", i, ex_ctrl_o, ex_rd_o, ex_op_a_o, ex_valid_o); end
    end
    flush_i = 1;
    step();
    flush_i = 0;
    exp_bubbles++;
    checks++; if (ex_valid_o !== 1'b0 || ex_ctrl_o !== 16'h0 || ex_rd_o !== 4'd0) begin errors++; $display("FAIL hold_flush: got v%h ctrl %h rd %h expected 0 0 0", ex_valid_o, ex_ctrl_o, ex_rd_o); end
    ex_hold_i = 0;
    drive(1'b1, 16'h0181, 4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 32'd100, 32'd0, 32'd4);
    step();
    ex_hold_i = 1;
    drive(1'b1, 16'h00B1, 4'd2, 1'b1, 4'd7, 1'b1, 4'd5, 32'd20, 32'd30, 32'd0);
    step();
    checks++; if (ex_ctrl_o !== 16'h0181 || ex_rd_o !== 4'd2) begin errors++; $display("FAIL hold_hazard_keep: got ctrl %h rd %h expected 0181 2", ex_ctrl_o, ex_rd_o); end
    checks++; if (bubble_count_o !== exp_count()) begin errors++; $display("FAIL hold_hazard_count: got %0d expected %0d", bubble_count_o, exp_count()); end
    ex_hold_i = 0;
    #1;
    checks++; if (stall_upstream_o !== 1'b1) begin errors++; $display("FAIL hold_hazard_reeval: got %h expected 1", stall_upstream_o); end
    step();
    exp_bubbles++;
    checks++; if (ex_valid_o !== 1'b0 || ex_ctrl_o !== 16'h0) begin errors++; $display("FAIL hold_hazard_bubble: got v%h ctrl %h expected 0 0", ex_valid_o, ex_ctrl_o); end
    step();
    checks++; if (ex_ctrl_o !== 16'h00B1 || ex_rd_o !== 4'd5) begin errors++; $display("FAIL hold_hazard_add: got ctrl %h rd %h expected 00b1 5", ex_ctrl_o, ex_rd_o); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'h0181, 4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 32'd100, 32'd0, 32'd4);
    step();
    drive(1'b1, 16'h00B1, 4'd2, 1'b1, 4'd7, 1'b1, 4'd5, 32'd20, 32'd30, 32'd0);
    checks++; if (stall_upstream_o !== 1'b1) begin errors++; $display("FAIL ar_stall_pre: got %h expected 1", stall_upstream_o); end
    #1;
    rst_n = 0;
    #1;
    checks++; if (ex_valid_o !== 1'b0 || ex_ctrl_o !== 16'h0 || ex_rd_o !== 4'd0 || ex_op_a_o !== 32'd0 || ex_imm_o !== 32'd0) begin errors++; $display("FAIL ar_clear: got v%h ctrl %h rd %h a %h imm %h expected all 0", ex_valid_o, ex_ctrl_o, ex_rd_o, ex_op_a_o, ex_imm_o); end
    checks++; if (stall_upstream_o !== 1'b0) begin errors++; $display("FAIL ar_stall_drop: got %h expected 0", stall_upstream_o); end
    checks++; if (bubble_count_o !== 32'd0) begin errors++; $display("FAIL ar_count: got %0d expected 0", bubble_count_o); end
    ex_hold_i = 1;
    #1;
    checks++; if (stall_upstream_o !== 1'b1) begin errors++; $display("FAIL ar_stall_hold: got %h expected 1", stall_upstream_o); end
    ex_hold_i = 0;
    exp_bubbles = 0;
    @(negedge clk);
    rst_n = 1;
    step();
    checks++; if (ex_ctrl_o !== 16'h00B1 || ex_rd_o !== 4'd5) begin errors++; $display("FAIL ar_resume: got ctrl %h rd %h expected 00b1 5", ex_ctrl_o, ex_rd_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ctrl_masking();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register that sits directly downstream of the control unit and the register-file read in decode. It latches the 16-bit control bundle, the register indices and the operands into the execute stage, and detects load-use hazards. On a hazard it inserts a NOP bubble and stalls the front end. It also supports flush (bubble insertion on a taken branch) and hold (back-pressure from later stages).

## Interface
- DATA_W, 32, operand/immediate width
- REG_AW, 4, register index width
- CTRL_W, 16, control bundle width; the field map is fixed below
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid_i  in  1  decode slot holds a real instruction
- id_ctrl_i  in  CTRL_W  control bundle: [8] load, [7] wre, [6] write_memory_enable, [5:4] writeback mux select, [3:0] aluOp; [15:9] are zero
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  source and destination indices
- id_rs1_used_i, id_rs2_used_i  in  1  the instruction actually reads rs1/rs2
- id_op_a_i, id_op_b_i, id_imm_i  in  DATA_W  register-file read data and immediate
- ex_hold_i  in  1  downstream hold; register keeps its contents
- flush_i  in  1  kill the decode-slot instruction (taken branch)
- ex_valid_o, ex_ctrl_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_op_a_o, ex_op_b_o, ex_imm_o  out  matching widths  registered execute-stage copies
- stall_upstream_o  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_count_o  out  32  bubbles inserted by hazard or flush (see Configuration)

## Operation
- Load-use hazard, combinational, on current state:
  - ex_valid_o & ex_ctrl_o[8] & ex_ctrl_o[7] & id_valid_i
  - & ((id_rs1_used_i & id_rs1_i==ex_rd_o) | (id_rs2_used_i & id_rs2_i==ex_rd_o))
  - Register 0 gets no special case.
- stall_upstream_o = hazard | ex_hold_i.
- Next-state priority, evaluated on each rising clk:
  1. flush_i: load a bubble.
  2. ex_hold_i: keep all registers unchanged.
  3. hazard: load a bubble.
  4. Otherwise: load all id_* inputs; ex_valid_o <= id_valid_i.
- Bubble definition:
  - ex_valid_o=0 and ex_ctrl_o=16'h0000 (the NOP encoding: no load, no wre, no memory write, mux 00, aluOp 0000).
  - Data, index and immediate fields are also cleared to 0, so a bubble is fully deterministic.
- When id_valid_i=0, the captured ex_ctrl_o is forced to 0 regardless of id_ctrl_i.
- Bits [15:9] of ex_ctrl_o are always driven 0.

## Timing
- Latency one cycle: inputs sampled at edge N appear on ex_*_o after edge N.
- Hazard resolves in exactly one bubble cycle. After the bubble, the load has left EX, so ex_valid_o=0 and the hazard clears.
- A hazard asserted together with ex_hold_i holds the register; no bubble is inserted and the hazard is re-evaluated next cycle.
- flush_i together with ex_hold_i: the flush wins and the EX contents are destroyed. Upstream must not flush while holding.
- Asynchronous reset: every output register goes to 0 immediately (ex_valid_o=0, ex_ctrl_o=0, all data 0, bubble_count_o=0).
  - stall_upstream_o then follows from the cleared state, so it equals ex_hold_i.
  - Reset in the middle of a stall or flush discards the in-flight instruction.
- Reset release is synchronous to clk by the system reset synchroniser; no internal synchroniser is used.

## Configuration
- ID_EX_PERF_CNT_EN defined:
  - bubble_count_o is a 32-bit counter that increments once per edge where a bubble is loaded (flush or hazard path).
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared only by reset.
- ID_EX_PERF_CNT_EN undefined: no counter flops; bubble_count_o is tied to 0.

## Structure
- Shared package pipeline_pkg holds:
  - CTRL_W and the field bit positions (CTRL_LOAD_BIT=8, CTRL_WRE_BIT=7, CTRL_WME_BIT=6, CTRL_WB_LSB=4, CTRL_ALU_LSB=0)
  - CTRL_NOP=16'h0000
  - a packed struct id_ex_t carrying valid, ctrl, indices and data
- One sub-module, load_use_detector: purely combinational hazard compare, reused by later forwarding logic.
- The register itself is one always_ff with async reset over id_ex_t.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all ex_*_o=0, bubble_count_o=0. Release, then apply add (ctrl 16'h00B1, rd=3, op_a=5, op_b=7) -> next cycle ex_ctrl_o=16'h00B1, ex_rd_o=3, ex_op_a_o=5.
- Load-use: ldr (ctrl 16'h0181, rd=2) followed by add with rs1=2 used -> stall_upstream_o=1 for one cycle, EX gets one bubble (ctrl 0), then the add enters EX; bubble_count_o=1 with the macro.
- No false hazard: ldr rd=2, then add rs1=2 with id_rs1_used_i=0 and rs2=4 -> stall_upstream_o stays 0 and the add enters EX with no bubble.
- Flush: flush_i=1 with a valid str (16'h0040) in decode -> ex_valid_o=0, ex_ctrl_o=0 next cycle; the counter increments.
- Hold: ex_hold_i=1 for 3 cycles with changing inputs -> ex_*_o unchanged and stall_upstream_o=1. Flush during a hold -> bubble loaded.
- Async reset mid-hazard: assert rst_n=0 between edges while stall_upstream_o=1 -> outputs clear immediately and stall_upstream_o drops to ex_hold_i.
